// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types, constants and width helper for the FIFO write arbiter
// Purpose: arbiter FSM state encoding, stall counter width, clog2-style width function.
// Ports: none (package).
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_e;

   localparam int STALL_W = 16;

   // Bits needed to index n values; never less than 1 so a 1-entry range still has a wire.
   function automatic int clog2w(input int n);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin picker
// Purpose: find the first asserted request searching upward from last_grant+1, wrapping.
// Ports:
//   req_i        in  num_req  request vector
//   last_grant_i in  id_w     index granted most recently
//   found_o      out 1        some request is asserted
//   winner_o     out id_w     index of the selected request (0 when none)
module rr_picker
   import fifo_arb_pkg::*;
#(
   parameter int num_req = 4,
   parameter int id_w    = clog2w(num_req)
) (
   input  logic [num_req-1:0] req_i,
   input  logic [id_w-1:0]    last_grant_i,
   output logic               found_o,
   output logic [id_w-1:0]    winner_o
);

   int               idx;
   logic [id_w-1:0]  idx_w;

   // Scan from the farthest offset down to the nearest so the nearest hit is written last.
   always_comb begin
      found_o  = 1'b0;
      winner_o = '0;
      idx      = 0;
      idx_w    = '0;
      for (int i = num_req; i >= 1; i--) begin
         idx = int'(last_grant_i) + i;
         if (idx >= num_req) idx = idx - num_req;
         idx_w = id_w'(idx);
         if (req_i[idx_w]) begin
            found_o  = 1'b1;
            winner_o = idx_w;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the FIFO write port
// Purpose: share one FIFO write port among num_req producers, bounded bursts, full-aware.
// Ports:
//   wr_clk_i     in  1                   write clock
//   rst_n_i      in  1                   async active-low reset
//   req_i        in  num_req             per-requester word available
//   req_data_i   in  num_req*data_width  requester i word at [i*data_width +: data_width]
//   fifo_full_i  in  1                   FIFO full flag
//   ack_o        out num_req             word of requester i accepted this cycle
//   wr_en_o      out 1                   FIFO write enable
//   wdata_o      out data_width          FIFO write data (0 when not writing)
//   grant_id_o   out clog2(num_req)      current owner
//   busy_o       out 1                   grant active
//   stall_cnt_o  out 16                  saturating count of full-blocked owner cycles
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int data_width = 8,
   parameter  int num_req    = 4,
   parameter  int max_burst  = 4,
   localparam int ID_W       = clog2w(num_req)
) (
   input  logic                          wr_clk_i,
   input  logic                          rst_n_i,
   input  logic [num_req-1:0]            req_i,
   input  logic [num_req*data_width-1:0] req_data_i,
   input  logic                          fifo_full_i,
   output logic [num_req-1:0]            ack_o,
   output logic                          wr_en_o,
   output logic [data_width-1:0]         wdata_o,
   output logic [ID_W-1:0]               grant_id_o,
   output logic                          busy_o,
   output logic [STALL_W-1:0]            stall_cnt_o
);

   localparam int BEAT_W = clog2w(max_burst + 1);

   state_e              state_q, state_d;
   logic [ID_W-1:0]     owner_q, owner_d;
   logic [ID_W-1:0]     last_q, last_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [STALL_W-1:0]  stall_q, stall_d;

   logic                pick_found;
   logic [ID_W-1:0]     pick_winner;
   logic                own_req;
   logic                accept;
   logic                blocked;
   logic                last_beat;

   rr_picker #(
      .num_req (num_req),
      .id_w    (ID_W)
   ) u_picker (
      .req_i        (req_i),
      .last_grant_i (last_q),
      .found_o      (pick_found),
      .winner_o     (pick_winner)
   );

   assign own_req   = req_i[owner_q];
   assign accept    = (state_q == BURST) && own_req && !fifo_full_i;
   assign blocked   = (state_q == BURST) && own_req && fifo_full_i;
   assign last_beat = (beat_q == BEAT_W'(max_burst - 1));

   // Write-side outputs follow the live req/full so a full flag blocks the write in the same cycle.
   always_comb begin
      ack_o   = '0;
      wr_en_o = 1'b0;
      wdata_o = '0;
      if (accept) begin
         ack_o[owner_q] = 1'b1;
         wr_en_o        = 1'b1;
         wdata_o        = req_data_i[int'(owner_q)*data_width +: data_width];
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      beat_d  = beat_q;
      stall_d = stall_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               owner_d = pick_winner;
               beat_d  = '0;
               state_d = BURST;
            end
         end
         BURST: begin
            if (!own_req) begin
               // Requester let go early; rotate past it.
               last_d  = owner_q;
               state_d = IDLE;
            end else if (fifo_full_i) begin
               if (stall_q != '1) stall_d = stall_q + 1'b1;
            end else if (last_beat) begin
               last_d  = owner_q;
               state_d = IDLE;
            end else begin
               beat_d = beat_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wr_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         owner_q <= '0;
         last_q  <= ID_W'(num_req - 1);
         beat_q  <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         beat_q  <= beat_d;
         stall_q <= stall_d;
      end
   end

   assign busy_o      = (state_q == BURST);
   assign grant_id_o  = owner_q;
   assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [7:0]  word [4];
   logic [31:0] req_data;
   logic        full;
   logic [3:0]  ack;
   logic        wr_en;
   logic [7:0]  wdata;
   logic [1:0]  gid;
   logic        busy;
   logic [15:0] stall;

   int total = 0;
   int bad   = 0;

   assign req_data = {word[3], word[2], word[1], word[0]};

   always #5 clk = ~clk;

   fifo_wr_arbiter #(
      .data_width (8),
      .num_req    (4),
      .max_burst  (4)
   ) dut (
      .wr_clk_i    (clk),
      .rst_n_i     (rst_n),
      .req_i       (req),
      .req_data_i  (req_data),
      .fifo_full_i (full),
      .ack_o       (ack),
      .wr_en_o     (wr_en),
      .wdata_o     (wdata),
      .grant_id_o  (gid),
      .busy_o      (busy),
      .stall_cnt_o (stall)
   );

   typedef struct {
      logic        rst_n;
      logic [3:0]  req;
      logic        full;
      logic [3:0]  ack;
      logic        wr;
      logic [7:0]  wdata;
      logic        busy;
      logic [1:0]  gid;
      logic [15:0] stall;
   } vec_t;

   vec_t vt [15];

   function automatic vec_t mk(input logic r, input logic [3:0] q, input logic f,
                               input logic [3:0] a, input logic w, input logic [7:0] d,
                               input logic b, input logic [1:0] g, input logic [15:0] s);
      vec_t v;
      v.rst_n = r; v.req = q; v.full = f; v.ack = a; v.wr = w;
      v.wdata = d; v.busy = b; v.gid = g; v.stall = s;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      full  = 1'b0;
      tick();
      tick();
      chk("rst.busy", 32'(busy), 0);
      chk("rst.wr_en", 32'(wr_en), 0);
      chk("rst.stall", 32'(stall), 0);
      rst_n = 1'b1;
   endtask

   logic [3:0] a_q;
   logic [3:0] e4;
   logic       e1;
   int         rcv;
   int         seq   [4];
   int         waits [4];
   logic       prev_busy;
   int         k;

   initial begin
      for (int i = 0; i < 4; i++) word[i] = 8'h11 * 8'(i + 1);

      // ---------------- table-driven vectors ----------------
      vt[0]  = mk(1, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 2'd0, 16'd0);
      vt[1]  = mk(1, 4'b0110, 0, 4'b0000, 0, 8'h00, 0, 2'd0, 16'd0);
      vt[2]  = mk(1, 4'b0110, 0, 4'b0010, 1, 8'h22, 1, 2'd1, 16'd0);
      vt[3]  = mk(1, 4'b0110, 1, 4'b0000, 0, 8'h00, 1, 2'd1, 16'd0);
      vt[4]  = mk(1, 4'b0100, 0, 4'b0000, 0, 8'h00, 1, 2'd1, 16'd1);
      vt[5]  = mk(1, 4'b0100, 0, 4'b0000, 0, 8'h00, 0, 2'd1, 16'd1);
      vt[6]  = mk(1, 4'b0100, 0, 4'b0100, 1, 8'h33, 1, 2'd2, 16'd1);
      vt[7]  = mk(1, 4'b0100, 0, 4'b0100, 1, 8'h33, 1, 2'd2, 16'd1);
      vt[8]  = mk(1, 4'b0100, 0, 4'b0100, 1, 8'h33, 1, 2'd2, 16'd1);
      vt[9]  = mk(1, 4'b0100, 0, 4'b0100, 1, 8'h33, 1, 2'd2, 16'd1);
      vt[10] = mk(1, 4'b0101, 0, 4'b0000, 0, 8'h00, 0, 2'd2, 16'd1);
      vt[11] = mk(1, 4'b0101, 0, 4'b0001, 1, 8'h11, 1, 2'd0, 16'd1);
      vt[12] = mk(0, 4'b0101, 0, 4'b0000, 0, 8'h00, 0, 2'd0, 16'd0);
      vt[13] = mk(1, 4'b0101, 0, 4'b0000, 0, 8'h00, 0, 2'd0, 16'd0);
      vt[14] = mk(1, 4'b0101, 0, 4'b0001, 1, 8'h11, 1, 2'd0, 16'd0);

      do_reset();
      for (int r = 0; r < 15; r++) begin
         rst_n = vt[r].rst_n;
         req   = vt[r].req;
         full  = vt[r].full;
         #3;
         chk($sformatf("v%0d.ack", r),   32'(ack),   32'(vt[r].ack));
         chk($sformatf("v%0d.wr", r),    32'(wr_en), 32'(vt[r].wr));
         chk($sformatf("v%0d.wdata", r), 32'(wdata), 32'(vt[r].wdata));
         chk($sformatf("v%0d.busy", r),  32'(busy),  32'(vt[r].busy));
         chk($sformatf("v%0d.gid", r),   32'(gid),   32'(vt[r].gid));
         chk($sformatf("v%0d.stall", r), 32'(stall), 32'(vt[r].stall));
         tick();
      end

      // ---------------- single requester, 10 words ----------------
      do_reset();
      word[0] = 8'd0;
      req     = 4'b0001;
      rcv     = 0;
      for (int c = 0; c < 14; c++) begin
         #3;
         e1 = (c inside {1, 2, 3, 4, 6, 7, 8, 9, 11, 12});
         chk($sformatf("single.c%0d.ack0", c), 32'(ack[0]), 32'(e1));
         if (ack[0]) begin
            chk($sformatf("single.w%0d", rcv), 32'(wdata), 32'(rcv));
            rcv++;
         end
         a_q = ack;
         tick();
         if (a_q[0]) begin
            word[0] = word[0] + 8'd1;
            if (word[0] == 8'd10) req = 4'b0000;
         end
      end
      chk("single.count", 32'(rcv), 32'd10);

      // ---------------- round robin, all requesting ----------------
      do_reset();
      for (int i = 0; i < 4; i++) word[i] = 8'h11 * 8'(i + 1);
      req = 4'b1111;
      for (int c = 0; c < 40; c++) begin
         #3;
         e4 = (c % 5 == 0) ? 4'b0000 : 4'(1 << ((c / 5) % 4));
         chk($sformatf("rr.c%0d.ack", c), 32'(ack), 32'(e4));
         if (c % 5 != 0) chk($sformatf("rr.c%0d.gid", c), 32'(gid), 32'((c / 5) % 4));
         tick();
      end

      // ---------------- full backpressure on owner 2 ----------------
      do_reset();
      word[2] = 8'd1;
      req     = 4'b0100;
      for (int c = 0; c < 11; c++) begin
         full = (c >= 3 && c <= 7);
         #3;
         e1 = (c inside {1, 2, 8, 9});
         chk($sformatf("bp.c%0d.wr", c), 32'(wr_en), 32'(e1));
         if (c >= 1 && c <= 9) begin
            chk($sformatf("bp.c%0d.busy", c), 32'(busy), 1);
            chk($sformatf("bp.c%0d.gid", c), 32'(gid), 2);
         end
         if (wr_en) chk($sformatf("bp.c%0d.wdata", c), 32'(wdata), 32'(word[2]));
         if (c == 8) chk("bp.stall", 32'(stall), 5);
         a_q = ack;
         tick();
         if (a_q[2]) begin
            word[2] = word[2] + 8'd1;
            if (word[2] == 8'd5) req = 4'b0000;
         end
      end
      full = 1'b0;

      // ---------------- early release by requester 1 ----------------
      do_reset();
      for (int i = 0; i < 4; i++) word[i] = 8'h11 * 8'(i + 1);
      req = 4'b0110;
      for (int c = 0; c < 6; c++) begin
         if (c == 3) req = 4'b0101;
         #3;
         case (c)
            1, 2:    e4 = 4'b0010;
            5:       e4 = 4'b0100;
            default: e4 = 4'b0000;
         endcase
         e1 = (c != 0 && c != 4);
         chk($sformatf("er.c%0d.ack", c), 32'(ack), 32'(e4));
         chk($sformatf("er.c%0d.busy", c), 32'(busy), 32'(e1));
         if (c == 3) chk("er.gid_hold", 32'(gid), 1);
         if (c == 5) chk("er.next_gid", 32'(gid), 2);
         tick();
      end

      // ---------------- random scoreboard ----------------
      do_reset();
      req = '0;
      prev_busy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         seq[i]   = 0;
         waits[i] = 0;
      end
      for (int cyc = 0; cyc < 10000; cyc++) begin
         full = ($urandom_range(0, 99) < 30);
         for (int i = 0; i < 4; i++) begin
            if (!req[i] && $urandom_range(0, 3) == 0) begin
               req[i]  = 1'b1;
               word[i] = {2'(i), 6'(seq[i])};
            end
         end
         #3;
         chk("rnd.wr_full", 32'(wr_en & full), 0);
         chk("rnd.onehot", 32'($countones(ack) <= 1), 1);
         chk("rnd.wr_ack", 32'(wr_en), 32'(|ack));
         if (wr_en) begin
            k = 0;
            for (int i = 0; i < 4; i++) if (ack[i]) k = i;
            chk("rnd.ack_owner", 32'(k), 32'(gid));
            chk($sformatf("rnd.order.r%0d", k), 32'(wdata), 32'({2'(k), 6'(seq[k])}));
         end
         for (int i = 0; i < 4; i++) if (!req[i]) waits[i] = 0;
         if (busy && !prev_busy) begin
            for (int i = 0; i < 4; i++) begin
               if (i == int'(gid)) waits[i] = 0;
               else if (req[i]) begin
                  waits[i]++;
                  chk($sformatf("rnd.starve.r%0d", i), 32'(waits[i] <= 3), 1);
               end
            end
         end
         a_q       = ack;
         prev_busy = busy;
         tick();
         for (int i = 0; i < 4; i++) begin
            if (a_q[i]) begin
               seq[i]++;
               if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
               else word[i] = {2'(i), 6'(seq[i])};
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter that shares the single write port of the team's asynchronous FIFO among `num_req` producers in the write clock domain. It grants the port round-robin in bounded bursts and drives `wr_en`/`wdata` into the FIFO. It also honours the FIFO `full` flag so no producer write is ever lost, and records per-requester stall activity. The block sits directly in front of the FIFO write side and runs only on the write clock.

## Interface
- `data_width`, 8, width of one data word; must match the FIFO.
- `num_req`, 4, number of requesters, 2..8.
- `max_burst`, 4, maximum words accepted per grant, 1..16.
- `wr_clk`  in  1  write-domain clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low; one clock, async active-low reset as decided.
- `req`  in  num_req  per-requester "word available"; must hold with stable data until acked.
- `req_data`  in  num_req*data_width  requester i's word in bits [i*data_width +: data_width].
- `fifo_full`  in  1  FIFO `full` flag.
- `ack`  out  num_req  one-hot or zero; word of requester i accepted this cycle.
- `wr_en`  out  1  FIFO write enable.
- `wdata`  out  data_width  FIFO write data.
- `grant_id`  out  clog2(num_req)  current owner index; valid while `busy`.
- `busy`  out  1  a grant is active (state BURST).
- `stall_cnt`  out  16  cycles in which owner had `req` high but `fifo_full` blocked it; saturating.

## Operation
- FSM states: IDLE, BURST.
- IDLE:
  - If any `req` is high, the round-robin picker selects the first requester with `req` high, searching from `last_grant+1` upward with modulo `num_req`.
  - Register the winner in `owner`/`grant_id`, clear `beat_cnt`, and go to BURST.
  - No `ack` is issued in IDLE.
- BURST: the accept condition is `req[owner] && !fifo_full`.
  - Accept: `ack[owner]=1`, `wr_en=1`, `wdata=req_data[owner]`, `beat_cnt++`.
  - Accept with `beat_cnt==max_burst-1`: set `last_grant<=owner` and go to IDLE.
  - `req[owner]` low: no ack; set `last_grant<=owner` and go to IDLE. The requester released early.
  - `req[owner]` high and `fifo_full` high: hold state, hold `beat_cnt`, increment `stall_cnt` (saturate at 0xFFFF).
- `ack`, `wr_en` and `wdata` are combinational from registered `state`/`owner` and from the live `req`/`fifo_full`. `wr_en` is never high when `fifo_full` is high, so the FIFO `overflow` can never assert due to this block.
- `wdata` is 0 when `wr_en` is low.
- Requesters other than `owner` never see `ack`, and at most one `ack` bit is high per cycle.

## Timing
- Reset: async assert when `rst_n` goes low. All outputs go to 0, state goes to IDLE, `last_grant=num_req-1` (so requester 0 wins first), `beat_cnt=0`, `stall_cnt=0`.
- Deassertion of `rst_n` is synchronised externally. The first grant decision can happen on the first edge after release.
- Latency: `req` high in cycle n (in IDLE) gives the first `ack` in cycle n+1 if the FIFO is not full.
- Throughput: a burst of k words occupies k cycles plus one IDLE arbitration cycle. Peak rate is max_burst/(max_burst+1).
- Wrap-around: the pointer search wraps from num_req-1 to 0. `beat_cnt` is clog2(max_burst+1) bits wide and never exceeds max_burst-1.
- Simultaneous requests in IDLE: only the picker winner is granted. The others wait at most (num_req-1) bursts, so there is no starvation.
- `fifo_full` rising mid-burst: the owner keeps the grant, the burst resumes when full clears, and `beat_cnt` is preserved.
- Reset mid-burst: the grant is abandoned immediately. A word that was not acked is not written, and the requester must keep holding it.
- `fifo_full` sampled each cycle. The 2-FF pessimism of the FIFO flag only delays writes; it never drops them.

## Structure
- Package `fifo_arb_pkg`:
  - state encoding IDLE=1'b0, BURST=1'b1;
  - `STALL_W=16`;
  - a function for the clog2 width calculation.
- Sub-module `rr_picker`: combinational only. Inputs are `req` and `last_grant`; outputs are `found` and `winner` index. It is reusable for the read-side scheduler.
- Top: FSM, `owner`/`beat_cnt`/`last_grant`/`stall_cnt` registers, and the data mux.

## Test plan
- Reset: with `rst_n=0` mid-stream, all outputs read 0 within the same cycle, and `stall_cnt=0` after release.
- Single requester: `req=4'b0001` held for 10 words, full=0. Expect `ack[0]` in cycles 1-4, 6-9 and 11-12, with one idle cycle between bursts. The FIFO must receive exactly words 0..9 in order.
- Round-robin: `req=4'b1111` constant, each requester sending 4 words. Expect grant order 0,1,2,3,0… and each burst exactly 4 acks.
- Full backpressure: owner 2 in BURST, `fifo_full` high for 5 cycles after the 2nd word. Expect no `wr_en` during those 5 cycles, `stall_cnt=5`, and the burst resuming to complete words 3-4 with owner still 2.
- Early release: requester 1 drops `req` after 2 words. Expect a return to IDLE, `last_grant=1`, and requester 2 granted next if it is requesting.
- Scoreboard: random `req`/`fifo_full` traffic for 10k cycles. Check no `wr_en` while full, at most one `ack` bit per cycle, per-requester order preserved, and no requester waiting more than 3 bursts.
